// File: rtl/disp_mode_if.sv
// Front-panel bundle between the keypad/calculator/stopwatch side and disp_mode_ctrl.
// The master drives keys and source values; the slave (controller) returns mode and display data.
interface disp_mode_if #(
    parameter int DATA_W = 32,
    parameter int DIGITS = 4
);
    logic                  key_valid;
    logic [3:0]            key_code;
    logic [DATA_W-1:0]     sw_count;
    logic [DATA_W-1:0]     calc_result;
    logic                  calc_neg;
    logic                  mode;
    logic [1:0]            sw_cmd;
    logic                  lap_active;
    logic [4*DIGITS-1:0]   digit_code;
    logic                  disp_valid;
    logic                  overflow;

    modport master (
        output key_valid, key_code, sw_count, calc_result, calc_neg,
        input  mode, sw_cmd, lap_active, digit_code, disp_valid, overflow
    );

    modport slave (
        input  key_valid, key_code, sw_count, calc_result, calc_neg,
        output mode, sw_cmd, lap_active, digit_code, disp_valid, overflow
    );
endinterface

// File: rtl/disp_mode_ctrl.sv
// Keypad mode/stopwatch command decoder plus a free-running sequential double-dabble
// formatter that publishes per-digit display codes with sign, overflow and blanking.
module disp_mode_ctrl #(
    parameter int DATA_W = 32,
    parameter int DIGITS = 4,
    parameter int LZB    = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    disp_mode_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    conv_state_t        state_r, state_nxt_s;
    logic               mode_r, mode_nxt_s;
    logic [1:0]         sw_cmd_r, sw_cmd_nxt_s;
    logic               lap_r, lap_nxt_s, lap_capture_s;
    logic [DATA_W-1:0]  lap_val_r;
    logic               src_change_s;
    logic [DATA_W-1:0]  src_val_s;
    logic               src_neg_s;
    logic [DATA_W-1:0]  bin_r;
    logic [BCD_W-1:0]   bcd_r, bcd_adj_s, bcd_shift_s;
    logic               neg_r, ovf_r, shift_out_s;
    logic [CNT_W-1:0]   cnt_r;
    int                 hi_s;
    logic               ovf_pub_s;
    logic [BCD_W-1:0]   fmt_s;
    logic [BCD_W-1:0]   digit_code_r;
    logic               disp_valid_r, overflow_r;

    // Key decode: next mode/command/lap state and whether the display source changes
    always_comb begin
        mode_nxt_s    = mode_r;
        sw_cmd_nxt_s  = sw_cmd_r;
        lap_nxt_s     = lap_r;
        lap_capture_s = 1'b0;
        src_change_s  = 1'b0;
        if (bus.key_valid) begin
            if (mode_r) begin
                if (bus.key_code == 4'd13) begin
                    mode_nxt_s   = 1'b0;
                    src_change_s = 1'b1;
                end else begin
                    mode_nxt_s = mode_r;
                end
            end else begin
                case (bus.key_code)
                    4'd14, 4'd15: begin
                        mode_nxt_s   = 1'b1;
                        src_change_s = 1'b1;
                    end
                    4'd13: sw_cmd_nxt_s = 2'd0;
                    4'd12: sw_cmd_nxt_s = 2'd1;
                    4'd10: begin
                        sw_cmd_nxt_s = 2'd2;
                        lap_nxt_s    = 1'b0;
                        src_change_s = 1'b1;
                    end
                    4'd11: begin
                        lap_nxt_s     = ~lap_r;
                        lap_capture_s = ~lap_r;
                        src_change_s  = 1'b1;
                    end
                    default: sw_cmd_nxt_s = sw_cmd_r;
                endcase
            end
        end else begin
            src_change_s = 1'b0;
        end
    end

    // Mode, stopwatch command and lap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r    <= 1'b1;
            sw_cmd_r  <= 2'd2;
            lap_r     <= 1'b0;
            lap_val_r <= '0;
        end else begin
            mode_r   <= mode_nxt_s;
            sw_cmd_r <= sw_cmd_nxt_s;
            lap_r    <= lap_nxt_s;
            if (lap_capture_s) begin
                lap_val_r <= bus.sw_count;
            end
        end
    end

    // Display source selection; only the calculator carries a sign
    always_comb begin
        if (mode_r) begin
            src_val_s = bus.calc_result;
        end else if (lap_r) begin
            src_val_s = lap_val_r;
        end else begin
            src_val_s = bus.sw_count;
        end
        src_neg_s = mode_r & bus.calc_neg;
    end

    // Converter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Converter next state; a source change in LOAD/SHIFT restarts from LOAD
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = ST_LOAD;
            ST_LOAD:  state_nxt_s = src_change_s ? ST_LOAD : ST_SHIFT;
            ST_SHIFT: begin
                if (src_change_s) begin
                    state_nxt_s = ST_LOAD;
                end else if (cnt_r == CNT_W'(DATA_W - 1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift the binary MSB in
    always_comb begin
        bcd_adj_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
        shift_out_s = bcd_adj_s[BCD_W-1];
        bcd_shift_s = {bcd_adj_s[BCD_W-2:0], bin_r[DATA_W-1]};
    end

    // Converter datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r <= '0;
            bcd_r <= '0;
            neg_r <= 1'b0;
            ovf_r <= 1'b0;
            cnt_r <= '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    bin_r <= src_val_s;
                    neg_r <= src_neg_s;
                    bcd_r <= '0;
                    ovf_r <= 1'b0;
                    cnt_r <= '0;
                end
                ST_SHIFT: begin
                    bcd_r <= bcd_shift_s;
                    bin_r <= {bin_r[DATA_W-2:0], 1'b0};
                    ovf_r <= ovf_r | shift_out_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                default: begin
                    bin_r <= bin_r;
                    bcd_r <= bcd_r;
                end
            endcase
        end
    end

    // Publish formatting: a negative value gives up its top digit to the minus sign
    always_comb begin
        hi_s = 0;
        for (int i = 0; i < DIGITS; i++) begin
            hi_s = (bcd_r[4*i +: 4] != 4'd0) ? i : hi_s;
        end
        ovf_pub_s = ovf_r | (neg_r & (bcd_r[BCD_W-1 -: 4] != 4'd0));
        fmt_s     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_pub_s) begin
                fmt_s[4*i +: 4] = 4'd12;
            end else if ((LZB != 0) && (i > hi_s)) begin
                fmt_s[4*i +: 4] = (neg_r && (i == hi_s + 1)) ? 4'd10 : 4'd11;
            end else if ((LZB == 0) && neg_r && (i == DIGITS - 1)) begin
                fmt_s[4*i +: 4] = 4'd10;
            end else begin
                fmt_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
    end

    // Registered display outputs, updated only when leaving DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_code_r <= {DIGITS{4'd11}};
            overflow_r   <= 1'b0;
            disp_valid_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
            digit_code_r <= fmt_s;
            overflow_r   <= ovf_pub_s;
            disp_valid_r <= 1'b1;
        end else begin
            disp_valid_r <= 1'b0;
        end
    end

    assign bus.mode       = mode_r;
    assign bus.sw_cmd     = sw_cmd_r;
    assign bus.lap_active = lap_r;
    assign bus.digit_code = digit_code_r;
    assign bus.disp_valid = disp_valid_r;
    assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Directed bench for disp_mode_ctrl: two instances (LZB=0 and LZB=1) share the same stimulus.
module tb_disp_mode_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n;

    always #5 clk = ~clk;

    disp_mode_if #(.DATA_W(32), .DIGITS(4)) if0 ();
    disp_mode_if #(.DATA_W(32), .DIGITS(4)) if1 ();

    assign if1.key_valid   = if0.key_valid;
    assign if1.key_code    = if0.key_code;
    assign if1.sw_count    = if0.sw_count;
    assign if1.calc_result = if0.calc_result;
    assign if1.calc_neg    = if0.calc_neg;

    disp_mode_ctrl #(.DATA_W(32), .DIGITS(4), .LZB(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    disp_mode_ctrl #(.DATA_W(32), .DIGITS(4), .LZB(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count negedges until disp_valid is seen, bounded
    task automatic wait_pub(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!if0.disp_valid && cyc < 200);
        if (!if0.disp_valid) check("pub_timeout", 32'd0, 32'd1);
    endtask

    task automatic fresh();
        int c;
        wait_pub(c);
        wait_pub(c);
    endtask

    task automatic press(input logic [3:0] k);
        if0.key_valid = 1'b1;
        if0.key_code  = k;
        @(negedge clk);
        if0.key_valid = 1'b0;
    endtask

    task automatic show(input string tag, input logic [15:0] e0, input logic [15:0] e1, input logic eovf);
        check({tag, "_lzb0"}, 32'(if0.digit_code), 32'(e0));
        check({tag, "_lzb1"}, 32'(if1.digit_code), 32'(e1));
        check({tag, "_ovf"}, 32'(if0.overflow), 32'(eovf));
    endtask

    initial begin
        if0.key_valid   = 1'b0;
        if0.key_code    = 4'd0;
        if0.sw_count    = 32'd0;
        if0.calc_result = 32'd1234;
        if0.calc_neg    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mode", 32'(if0.mode), 32'd1);
        check("rst_cmd", 32'(if0.sw_cmd), 32'd2);
        check("rst_lap", 32'(if0.lap_active), 32'd0);
        check("rst_digits", 32'(if0.digit_code), 32'h0000_BBBB);
        check("rst_dv", 32'(if0.disp_valid), 32'd0);
        check("rst_ovf", 32'(if0.overflow), 32'd0);

        rst_n = 1'b1;
        wait_pub(n);
        check("first_latency", 32'(n), 32'd35);
        show("v1234", 16'h1234, 16'h1234, 1'b0);
        @(negedge clk);
        check("dv_pulse", 32'(if0.disp_valid), 32'd0);
        wait_pub(n);
        check("refresh_period", 32'(n + 1), 32'd35);

        if0.calc_result = 32'd42;    if0.calc_neg = 1'b1; fresh();
        show("neg42", 16'hA042, 16'hBA42, 1'b0);
        if0.calc_result = 32'd10000; if0.calc_neg = 1'b0; fresh();
        show("ovf10000", 16'hCCCC, 16'hCCCC, 1'b1);
        if0.calc_result = 32'd999;   if0.calc_neg = 1'b1; fresh();
        show("neg999", 16'hA999, 16'hA999, 1'b0);
        if0.calc_result = 32'd1000;  if0.calc_neg = 1'b1; fresh();
        show("neg1000", 16'hCCCC, 16'hCCCC, 1'b1);
        if0.calc_result = 32'd0;     if0.calc_neg = 1'b0; fresh();
        show("zero", 16'h0000, 16'hBBB0, 1'b0);
        if0.calc_result = 32'd9999;  fresh();
        show("max9999", 16'h9999, 16'h9999, 1'b0);

        if0.calc_result = 32'd1234;
        press(4'd12);
        check("calc_ignore_cmd", 32'(if0.sw_cmd), 32'd2);
        check("calc_ignore_mode", 32'(if0.mode), 32'd1);
        press(4'd13);
        check("to_sw_mode", 32'(if0.mode), 32'd0);
        check("to_sw_cmd", 32'(if0.sw_cmd), 32'd2);
        press(4'd13);
        check("run_cmd", 32'(if0.sw_cmd), 32'd0);
        if0.sw_count = 32'd57;
        press(4'd11);
        check("lap_on", 32'(if0.lap_active), 32'd1);
        if0.sw_count = 32'd300;
        fresh();
        show("lap57", 16'h0057, 16'hBB57, 1'b0);
        if0.sw_count = 32'd301;
        wait_pub(n);
        show("lap_hold", 16'h0057, 16'hBB57, 1'b0);
        press(4'd11);
        check("lap_off", 32'(if0.lap_active), 32'd0);
        fresh();
        show("live301", 16'h0301, 16'hB301, 1'b0);

        wait_pub(n);
        repeat (10) @(negedge clk);
        check("stable_between", 32'(if0.digit_code), 32'h0000_0301);
        press(4'd14);
        check("back_calc", 32'(if0.mode), 32'd1);
        wait_pub(n);
        check("abort_latency", 32'(n), 32'd34);
        show("abort1234", 16'h1234, 16'h1234, 1'b0);

        wait_pub(n);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_digits", 32'(if0.digit_code), 32'h0000_BBBB);
        check("arst_dv", 32'(if0.disp_valid), 32'd0);
        check("arst_cmd", 32'(if0.sw_cmd), 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        wait_pub(n);
        check("rst_relatency", 32'(n), 32'd35);

        if0.key_valid = 1'b1;
        if0.key_code  = 4'd13;
        @(negedge clk);
        if0.key_code  = 4'd13;
        @(negedge clk);
        if0.key_valid = 1'b0;
        check("b2b_mode", 32'(if0.mode), 32'd0);
        check("b2b_cmd", 32'(if0.sw_cmd), 32'd0);
        press(4'd12);
        check("hold_cmd", 32'(if0.sw_cmd), 32'd1);
        press(4'd11);
        check("lap_on2", 32'(if0.lap_active), 32'd1);
        press(4'd10);
        check("clear_cmd", 32'(if0.sw_cmd), 32'd2);
        check("clear_lap", 32'(if0.lap_active), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
